// File: rtl/nibble_serial_addsub.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub
//
// Multi-cycle WIDTH-bit adder/subtractor. A single 4-bit carry-lookahead
// slice is reused once per clock, LSB nibble first. The carry between
// nibbles is kept in a register. Subtraction feeds ~B into the slice and
// starts with a carry-in of 1.
//
// Parameters:
//   WIDTH   operand/result width in bits (multiple of 4, >= 8)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   start   in   request; sampled only when not busy (IDLE or DONE)
//   sub     in   0 = A+B, 1 = A-B; sampled with start
//   A, B    in   operands; sampled with start
//   busy    out  operation in progress
//   done    out  one-cycle pulse, result and flags valid
//   result  out  sum/difference; held until the next accepted start
//   cout    out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf     out  two's-complement signed overflow
//   zero    out  result == 0
//
// Optional feature (macro NSA_GROUP_PG_EN):
//   grp_p   out  whole-word group propagate, accumulated nibble by nibble
//   grp_g   out  whole-word group generate, accumulated nibble by nibble
// -----------------------------------------------------------------------------
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
`ifdef NSA_GROUP_PG_EN
    ,
    output logic             grp_p,
    output logic             grp_g
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
`ifdef NSA_GROUP_PG_EN
    logic               gp_q, gp_d;
    logic               gg_q, gg_d;
`endif

    // -------------------------------------------------------------------------
    // 4-bit carry-lookahead slice on the current nibble
    // -------------------------------------------------------------------------
    logic [3:0] nib_a, nib_b;
    logic [3:0] bit_p, bit_g;
    logic [3:0] cy;          // cy[k] = carry into bit k of the nibble
    logic [3:0] nib_sum;
    logic       slice_p, slice_g;
    logic       c_next;

    always_comb begin
        nib_a = opa_q[{idx_q, 2'b00} +: 4];
        nib_b = opb_q[{idx_q, 2'b00} +: 4];
        bit_p = nib_a ^ nib_b;
        bit_g = nib_a & nib_b;

        cy[0] = c_q;
        cy[1] = bit_g[0] | (bit_p[0] & c_q);
        cy[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & c_q);
        cy[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
              | (bit_p[2] & bit_p[1] & bit_p[0] & c_q);

        nib_sum = bit_p ^ cy;
        slice_p = &bit_p;
        slice_g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
                | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
        c_next  = slice_g | (slice_p & c_q);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block
        // leaves a signal unassigned; that is what keeps it latch-free.
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        c_d      = c_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`ifdef NSA_GROUP_PG_EN
        gp_d     = gp_q;
        gg_d     = gg_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    opa_d    = A;
                    opb_d    = sub ? ~B : B;
                    c_d      = sub;          // +1 completes the two's complement of B
                    idx_d    = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
`ifdef NSA_GROUP_PG_EN
                    gp_d     = 1'b1;
                    gg_d     = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = nib_sum;
                c_d   = c_next;
                idx_d = idx_q + IDX_W'(1);
`ifdef NSA_GROUP_PG_EN
                // Higher nibble is folded in on the left of the accumulated group.
                gp_d  = gp_q & slice_p;
                gg_d  = slice_g | (slice_p & gg_q);
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = c_next;
                    // cy[3] here is the carry into bit WIDTH-1.
                    ovf_d   = cy[3] ^ c_next;
                    zero_d  = (result_d == '0);
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef NSA_GROUP_PG_EN
            gp_q     <= 1'b0;
            gg_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
`ifdef NSA_GROUP_PG_EN
            gp_q     <= gp_d;
            gg_q     <= gg_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
`ifdef NSA_GROUP_PG_EN
    assign grp_p  = gp_q;
    assign grp_g  = gg_q;
`endif

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice that produces sum, group propagate p and group generate g.
- Processes one nibble per clock, LSB nibble first, with a registered ripple carry between nibbles.
- Uses a start/done handshake toward the controlling datapath.
- Subtraction is the reverse operation: B is inverted and carry-in is forced to 1.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Reset is asynchronous, active-high. While rst=1: state=IDLE; busy, done, result, cout, ovf, zero, the carry register and the nibble index are all 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (accept edge k):
  - Latch A into opA, and (sub ? ~B : B) into opB.
  - Set carry register c = sub, index i = 0, clear result.
  - Go to RUN; busy=1.
- RUN, each edge:
  - Slice computes s = opA[4i+3:4i] + opB[4i+3:4i] + c.
  - Write result nibble i = s.
  - Next carry: c = g | (p & c).
  - Capture the carry into the MSB (bit WIDTH−1) when i = WIDTH/4−1.
  - Increment i.
- On the last nibble edge (k + WIDTH/4):
  - Go to DONE, busy=0, done=1.
  - cout = final c.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (final result == 0).
- DONE lasts exactly one cycle, then IDLE. done is high only in DONE.
- Latency: done rises WIDTH/4 clocks after the accept edge (4 clocks for WIDTH=16). Throughput: one operation per WIDTH/4+1 clocks.
- start during RUN is ignored: no effect on operands, state or outputs.
- start in DONE is accepted, giving back-to-back operation. done still pulses for one cycle; result/flags are then cleared by the new accept.
- Operand changes after the accept edge have no effect.
- rst asserted mid-RUN aborts immediately: all outputs go to 0, no done pulse. After release: IDLE.
- Arithmetic is modulo 2^WIDTH. Result is identical for signed and unsigned interpretation; only ovf is signed.

Optional Feature:
- Macro: NSA_GROUP_PG_EN.
- Defined:
  - Extra outputs grp_p (1) and grp_g (1): whole-word group propagate/generate, accumulated serially.
  - Update per nibble: P = P & p, G = g | (p & G).
  - Both are cleared to P=1, G=0 on accept and to 0 on reset; final values are valid with done.
  - Intended to feed a higher-level lookahead unit.
- Not defined: ports and logic are absent; all other behaviour is unchanged.

Test Plan:
1. WIDTH=16, A=0x1234, B=0x4321, sub=0 → result=0x5555, cout=0, ovf=0, zero=0; done exactly 4 clocks after the accept edge, one cycle wide.
2. A=0xFFFF, B=0x0001, sub=0 → result=0x0000, cout=1, zero=1, ovf=0. A=0x7FFF, B=0x0001 → result=0x8000, ovf=1, cout=0.
3. sub=1:
   - A=0x0005, B=0x0007 → result=0xFFFE, cout=0 (borrow), ovf=0.
   - A=0x8000, B=0x0001 → result=0x7FFF, cout=1, ovf=1.
4. Accept 0x1111+0x2222. Pulse start with A=0xFFFF, B=0xFFFF on RUN cycle 2 → ignored; result=0x3333. Start asserted in the DONE cycle → accepted, second done 5 clocks after the first.
5. Accept an operation, assert rst asynchronously during RUN (between edges) → busy/result/flags go to 0 without waiting for clk, no done pulse. After release, 0x0001+0x0001 → result=0x0002.
6. With NSA_GROUP_PG_EN:
   - 0x0F0F+0xF0F0 → grp_p=1, grp_g=0, result=0xFFFF.
   - 0xFFFF+0x0001 → grp_g=1, grp_p=0.
   - Without the macro: the bench compiles without grp_p/grp_g, and scenarios 1–5 pass unchanged.
